lc3b_alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the next-generation LC-3b execute stage. Opcode encodings 0–6 are the existing lc3b_aluop values. It adds XOR and an iterative multiply, and replaces the single-cycle barrel shift with an iterative shifter. It has a valid/ready request and response handshake so the pipeline can stall on long operations, and it provides result NZP flags, an error flag and a saturating completed-ops counter.

---
 rtl/lc3b_alu_mc.sv | 189 ++++++++++++++++++
 tb/tb_lc3b_alu_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_alu_mc.sv
// Multi-cycle LC-3b ALU: single-cycle logic ops plus iterative shifter and shift-add
// multiplier, wrapped in a valid/ready request/response handshake with NZP flags.
module lc3b_alu_mc #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic [2:0]         resp_nzp,
  output logic               resp_err,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_PASS = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  localparam logic [SHAMT_W:0] CNT_ONE    = (SHAMT_W+1)'(1);
  localparam logic [SHAMT_W:0] MUL_CYCLES = (SHAMT_W+1)'(WIDTH);
  localparam logic [CNT_W-1:0] OPS_ONE    = CNT_W'(1);

  state_t             state, state_next;
  logic [3:0]         op_reg, op_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic [SHAMT_W:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   data_reg, data_next;
  logic [2:0]         nzp_reg, nzp_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               multi_cycle;
  logic [WIDTH-1:0]   quick_data;
  logic               quick_err;
  logic [WIDTH-1:0]   shift_step;
  logic [WIDTH-1:0]   mul_sum;

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] d);
    if (d[WIDTH-1])      return 3'b100;
    else if (d == '0)    return 3'b010;
    else                 return 3'b001;
  endfunction

  assign shamt       = req_b[SHAMT_W-1:0];
  assign is_shift    = (req_op == OP_SLL) || (req_op == OP_SRL) || (req_op == OP_SRA);
  assign multi_cycle = (is_shift && (shamt != '0)) || (req_op == OP_MUL);

  // Results available on the accept edge; a zero-amount shift simply passes A.
  always_comb begin
    quick_data = '0;
    quick_err  = 1'b0;
    case (req_op)
      OP_ADD:                quick_data = req_a + req_b;
      OP_AND:                quick_data = req_a & req_b;
      OP_NOT:                quick_data = ~req_a;
      OP_PASS:               quick_data = req_a;
      OP_SLL, OP_SRL, OP_SRA: quick_data = req_a;
      OP_XOR:                quick_data = req_a ^ req_b;
      OP_MUL:                quick_data = '0;
      default:               quick_err  = 1'b1;
    endcase
  end

  always_comb begin
    case (op_reg)
      OP_SLL:  shift_step = a_reg << 1;
      OP_SRL:  shift_step = a_reg >> 1;
      default: shift_step = {a_reg[WIDTH-1], a_reg[WIDTH-1:1]};
    endcase
  end

  assign mul_sum = acc_reg + (b_reg[0] ? a_reg : '0);

  always_comb begin
    state_next = state;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    nzp_next   = nzp_reg;
    err_next   = err_reg;
    count_next = count_reg;

    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_next  = req_op;
            a_next   = req_a;
            b_next   = req_b;
            acc_next = '0;
            if (multi_cycle) begin
              state_next = BUSY;
              cnt_next   = (req_op == OP_MUL) ? MUL_CYCLES : {1'b0, shamt};
            end else begin
              state_next = DONE;
              data_next  = quick_data;
              nzp_next   = nzp_of(quick_data);
              err_next   = quick_err;
            end
          end
        end
        BUSY: begin
          cnt_next = cnt_reg - CNT_ONE;
          if (op_reg == OP_MUL) begin
            acc_next = mul_sum;
            a_next   = a_reg << 1;
            b_next   = b_reg >> 1;
          end else begin
            a_next = shift_step;
          end
          // The final iteration's result goes straight into the response register.
          if (cnt_reg == CNT_ONE) begin
            state_next = DONE;
            data_next  = (op_reg == OP_MUL) ? mul_sum : shift_step;
            nzp_next   = nzp_of((op_reg == OP_MUL) ? mul_sum : shift_step);
            err_next   = 1'b0;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_next = IDLE;
            if (count_reg != '1) count_next = count_reg + OPS_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      nzp_reg   <= 3'b010;
      err_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state     <= state_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      nzp_reg   <= nzp_next;
      err_reg   <= err_next;
      count_reg <= count_next;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_data  = data_reg;
  assign resp_nzp   = nzp_reg;
  assign resp_err   = err_reg;
  assign op_count   = count_reg;

endmodule

// File: tb/tb_lc3b_alu_mc.sv
// Randomized and directed bench for lc3b_alu_mc against an arithmetic reference model.
module tb_lc3b_alu_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic [2:0]  resp_nzp;
  logic        resp_err;
  logic [31:0] op_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_count = 0;

  lc3b_alu_mc dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_nzp(resp_nzp), .resp_err(resp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {err, data} from plain arithmetic on the operands
  function automatic logic [16:0] ref_result(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [15:0] r;
    int k;
    k = int'(b[3:0]);
    case (op)
      4'd0: r = a + b;
      4'd1: r = a & b;
      4'd2: r = ~a;
      4'd3: r = a;
      4'd4: r = a << k;
      4'd5: r = a >> k;
      4'd6: r = 16'($signed(a) >>> k);
      4'd7: r = a ^ b;
      4'd8: r = 16'(32'(a) * 32'(b));
      default: return {1'b1, 16'h0000};
    endcase
    return {1'b0, r};
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [15:0] b);
    if (op >= 4'd4 && op <= 4'd6) return (b[3:0] == 0) ? 1 : int'(b[3:0]) + 1;
    if (op == 4'd8) return 17;
    return 1;
  endfunction

  function automatic logic [2:0] ref_nzp(input logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 0)         return 3'b010;
    return 3'b001;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold);
    logic [16:0] r;
    int lat;
    int cyc;
    r   = ref_result(op, a, b);
    lat = ref_lat(op, b);
    cyc = 0;
    while (!req_ready && cyc < 100) begin tick(); cyc++; end
    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0; req_op = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    cyc = 1;
    while (!resp_valid && cyc < 100) begin
      check("busy_ready", 32'(req_ready), 32'd0);
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat));
    check("data", 32'(resp_data), 32'(r[15:0]));
    check("nzp", 32'(resp_nzp), 32'(ref_nzp(r[15:0])));
    check("err", 32'(resp_err), 32'(r[16]));
    check("done_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", 32'(resp_data), 32'(r[15:0]));
      check("hold_count", op_count, 32'(exp_count));
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    exp_count++;
    $display("op=%0h a=%04h b=%04h -> data=%04h nzp=%03b err=%0b lat=%0d", op, a, b,
             resp_data, resp_nzp, resp_err, cyc);
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
    check("count", op_count, 32'(exp_count));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_data"}, 32'(resp_data), 32'd0);
    check({tag, "_nzp"}, 32'(resp_nzp), 32'b010);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    check({tag, "_count"}, op_count, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    run_op(4'd0, 16'h7FFF, 16'h0001, 0);
    run_op(4'd6, 16'h8000, 16'h0003, 0);
    run_op(4'd5, 16'h8000, 16'h0003, 0);
    run_op(4'd8, 16'h0013, 16'h0007, 0);
    run_op(4'd8, 16'hFFFF, 16'hFFFF, 0);
    run_op(4'd7, 16'h00FF, 16'h0F0F, 5);
    run_op(4'hA, 16'h1234, 16'h5678, 0);
    run_op(4'd4, 16'h1234, 16'h0000, 1);

    // flush part-way through a multiply
    req_valid = 1'b1; req_op = 4'd8; req_a = 16'h1111; req_b = 16'h2222;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_valid", 32'(resp_valid), 32'd0);
    check("flush_busy_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("flush_busy_ghost", 32'(resp_valid), 32'd0);
    end
    check("flush_busy_count", op_count, 32'(exp_count));

    // flush beats the response handshake in DONE
    req_valid = 1'b1; req_op = 4'd7; req_a = 16'h00AA; req_b = 16'h0055;
    tick();
    req_valid = 1'b0;
    check("flush_done_pre", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1; flush = 1'b1;
    tick();
    resp_ready = 1'b0; flush = 1'b0;
    check("flush_done_valid", 32'(resp_valid), 32'd0);
    check("flush_done_ready", 32'(req_ready), 32'd1);
    check("flush_done_count", op_count, 32'(exp_count));

    // flush beats an accept in IDLE
    req_valid = 1'b1; req_op = 4'd0; req_a = 16'h0001; req_b = 16'h0001; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", 32'(req_ready), 32'd1);
    check("flush_idle_valid", 32'(resp_valid), 32'd0);

    run_op(4'd0, 16'h0002, 16'h0003, 0);

    // asynchronous reset during a 9-step shift
    req_valid = 1'b1; req_op = 4'd4; req_a = 16'h00F3; req_b = 16'h0009;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("pre_reset_busy", 32'(req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    exp_count = 0;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_valid", 32'(resp_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = (i % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      run_op(op, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
